calc_job_arbiter: RTL and testbench

- Round-robin scheduler that shares one sum-of-multiples calculation engine among N requesters.
- Accepts per-requester jobs, each a max value. Sequences the engine's level start/done handshake and returns each sum to its owner with a one-cycle ack.
- A watchdog aborts runaway jobs by resetting the engine and returning an error.
- Sits between the requesting blocks and the single calculation engine instance.

---
 rtl/calc_job_arbiter.sv | 163 ++++++++++++++++
 tb/tb_calc_job_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_job_arbiter.sv
// Round-robin front end sharing one sum-of-multiples engine among N_REQ requesters.
// Sequences the engine start/done handshake, acks each owner and aborts runaway jobs.
module calc_job_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 1000000
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] req_max,
    output logic [N_REQ-1:0]       ack,
    output logic [WIDTH-1:0]       result,
    output logic                   err,
    output logic                   busy,
    output logic                   calc_start,
    output logic [WIDTH-1:0]       calc_max,
    output logic                   calc_reset,
    input  logic [WIDTH-1:0]       calc_sum,
    input  logic                   calc_done,
    output logic [15:0]            jobs_done
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW    = $clog2(TIMEOUT);
    localparam logic [PTR_W:0]   NREQ_C  = (PTR_W+1)'(N_REQ);
    localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(N_REQ - 1);
    localparam logic [TW-1:0]    TLIM_C  = TW'(TIMEOUT - 1);
    localparam logic [N_REQ-1:0] ONEHOT0 = N_REQ'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [PTR_W-1:0]   r_rr;
    logic [PTR_W-1:0]   r_owner;
    logic [TW-1:0]      r_timer;
    logic [N_REQ-1:0]   r_ack;
    logic [WIDTH-1:0]   r_result;
    logic               r_err;
    logic               r_busy;
    logic               r_calc_start;
    logic [WIDTH-1:0]   r_calc_max;
    logic               r_calc_reset;
    logic [15:0]        r_jobs_done;
    logic [PTR_W:0]     w_cand;
    logic [PTR_W-1:0]   w_grant_idx;
    logic               w_grant_vld;
    logic               w_timeout;

    // Round-robin search: first set request at or above the pointer, wrapping.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_cand = {1'b0, r_rr} + (PTR_W+1)'(k);
            if (w_cand >= NREQ_C) begin
                w_cand = w_cand - NREQ_C;
            end else begin
                w_cand = w_cand;
            end
            if (!w_grant_vld && req[w_cand[PTR_W-1:0]]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = w_cand[PTR_W-1:0];
            end else begin
                w_grant_vld = w_grant_vld;
            end
        end
    end

    assign w_timeout = (r_timer == TLIM_C);

    // Next-state logic; done wins over timeout in RUN.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_grant_vld) w_state_next = S_RUN; else w_state_next = S_IDLE;
            S_RUN:   if (calc_done || w_timeout) w_state_next = S_DRAIN; else w_state_next = S_RUN;
            S_DRAIN: if (!calc_done) w_state_next = S_IDLE; else w_state_next = S_DRAIN;
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Job datapath: grant capture, run timer, completion/abort and ack pulse.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_rr         <= '0;
            r_owner      <= '0;
            r_timer      <= '0;
            r_ack        <= '0;
            r_result     <= '0;
            r_err        <= 1'b0;
            r_busy       <= 1'b0;
            r_calc_start <= 1'b0;
            r_calc_max   <= '0;
            r_calc_reset <= 1'b0;
            r_jobs_done  <= 16'd0;
        end else begin
            r_busy <= (w_state_next != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_grant_vld) begin
                        r_owner      <= w_grant_idx;
                        r_calc_max   <= req_max[w_grant_idx*WIDTH +: WIDTH];
                        r_calc_start <= 1'b1;
                        r_timer      <= '0;
                        r_rr         <= (w_grant_idx == LAST_C) ? '0 : w_grant_idx + PTR_W'(1);
                    end
                end
                S_RUN: begin
                    if (calc_done) begin
                        r_result     <= calc_sum;
                        r_ack        <= ONEHOT0 << r_owner;
                        r_err        <= 1'b0;
                        r_jobs_done  <= r_jobs_done + 16'd1;
                        r_calc_start <= 1'b0;
                    end else if (w_timeout) begin
                        r_result     <= '0;
                        r_ack        <= ONEHOT0 << r_owner;
                        r_err        <= 1'b1;
                        r_calc_start <= 1'b0;
                        r_calc_reset <= 1'b1;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_DRAIN: begin
                    r_ack        <= '0;
                    r_calc_reset <= 1'b0;
                end
                default: begin
                    r_ack        <= '0;
                    r_calc_reset <= 1'b0;
                    r_calc_start <= 1'b0;
                end
            endcase
        end
    end

    assign ack        = r_ack;
    assign result     = r_result;
    assign err        = r_err;
    assign busy       = r_busy;
    assign calc_start = r_calc_start;
    assign calc_max   = r_calc_max;
    assign calc_reset = r_calc_reset;
    assign jobs_done  = r_jobs_done;

endmodule

// File: tb/tb_calc_job_arbiter.sv
// Directed bench for calc_job_arbiter with a behavioural sum-of-multiples engine
// (multiples of 3 or 5 below max; max >= 500 never finishes).
module tb_calc_job_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = 4'b0000;
    logic [127:0] req_max = '0;
    logic [3:0]  ack;
    logic [31:0] result;
    logic        err;
    logic        busy;
    logic        calc_start;
    logic [31:0] calc_max;
    logic        calc_reset;
    logic [31:0] calc_sum;
    logic        calc_done;
    logic [15:0] jobs_done;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    calc_job_arbiter #(.N_REQ(4), .WIDTH(32), .TIMEOUT(20)) dut (
        .CLOCK_50(clk), .reset(reset), .req(req), .req_max(req_max),
        .ack(ack), .result(result), .err(err), .busy(busy),
        .calc_start(calc_start), .calc_max(calc_max), .calc_reset(calc_reset),
        .calc_sum(calc_sum), .calc_done(calc_done), .jobs_done(jobs_done)
    );

    function automatic logic [31:0] som(input logic [31:0] mx);
        logic [31:0] s;
        s = 32'd0;
        for (int i = 0; i < int'(mx); i++) begin
            if ((i % 3 == 0) || (i % 5 == 0)) s = s + 32'(i);
        end
        return s;
    endfunction

    int e_cnt;
    int e_drop;

    // Engine model: 4 cycles to done, done drops 2 cycles after start falls.
    always @(posedge clk or posedge reset) begin
        if (reset || calc_reset) begin
            calc_done <= 1'b0; calc_sum <= 32'd0; e_cnt <= 0; e_drop <= 0;
        end else if (calc_start) begin
            e_drop <= 0;
            if (!calc_done && calc_max < 32'd500) begin
                if (e_cnt == 3) begin
                    calc_done <= 1'b1;
                    calc_sum  <= som(calc_max);
                end else begin
                    e_cnt <= e_cnt + 1;
                end
            end
        end else begin
            e_cnt <= 0;
            if (calc_done) begin
                if (e_drop == 1) begin
                    calc_done <= 1'b0; e_drop <= 0;
                end else begin
                    e_drop <= e_drop + 1;
                end
            end
        end
    end

    task automatic wait_ack(output int cyc, output int low);
        cyc = 0; low = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (!calc_start) low++;
        end while (ack == 4'b0000 && cyc < 200);
        if (ack == 4'b0000) begin
            n_total++;
            $display("FAIL ack_wait no ack within %0d cycles, required an ack", cyc);
        end
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while (busy && c < 50) begin
            @(negedge clk);
            c++;
        end
        n_total++;
        if (busy !== 1'b0) $display("FAIL idle_wait busy=%b required 0", busy); else n_pass++;
    endtask

    task automatic apply_reset();
        reset = 1'b1; req = 4'b0000;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_total++; if (ack !== 4'b0000) $display("FAIL rst_ack got %b exp 0000", ack); else n_pass++;
        n_total++; if (result !== 32'd0) $display("FAIL rst_result got %0d exp 0", result); else n_pass++;
        n_total++; if ({err, busy, calc_start, calc_reset} !== 4'b0000)
            $display("FAIL rst_flags got %b exp 0000", {err, busy, calc_start, calc_reset}); else n_pass++;
        n_total++; if (calc_max !== 32'd0) $display("FAIL rst_calc_max got %0d exp 0", calc_max); else n_pass++;
        n_total++; if (jobs_done !== 16'd0) $display("FAIL rst_jobs got %0d exp 0", jobs_done); else n_pass++;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int cyc, low;
        req_max[31:0] = 32'd10; req = 4'b0001;
        @(negedge clk);
        n_total++; if (calc_start !== 1'b1) $display("FAIL single_start got %b exp 1", calc_start); else n_pass++;
        n_total++; if (calc_max !== 32'd10) $display("FAIL single_calc_max got %0d exp 10", calc_max); else n_pass++;
        n_total++; if (busy !== 1'b1) $display("FAIL single_busy got %b exp 1", busy); else n_pass++;
        wait_ack(cyc, low);
        req = 4'b0000;
        n_total++; if (ack !== 4'b0001) $display("FAIL single_ack got %b exp 0001", ack); else n_pass++;
        n_total++; if (result !== 32'd23) $display("FAIL single_result got %0d exp 23", result); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL single_err got %b exp 0", err); else n_pass++;
        n_total++; if (jobs_done !== 16'd1) $display("FAIL single_jobs got %0d exp 1", jobs_done); else n_pass++;
        @(negedge clk);
        n_total++; if (ack !== 4'b0000) $display("FAIL single_ack_pulse got %b exp 0000", ack); else n_pass++;
        n_total++; if (result !== 32'd23) $display("FAIL single_result_hold got %0d exp 23", result); else n_pass++;
        wait_idle();
    endtask

    task automatic test_two();
        int cyc, low;
        apply_reset();
        req_max[31:0] = 32'd10; req_max[95:64] = 32'd16; req = 4'b0101;
        wait_ack(cyc, low);
        req[0] = 1'b0;
        n_total++; if (ack !== 4'b0001) $display("FAIL two_ack0 got %b exp 0001", ack); else n_pass++;
        n_total++; if (result !== 32'd23) $display("FAIL two_result0 got %0d exp 23", result); else n_pass++;
        wait_ack(cyc, low);
        req[2] = 1'b0;
        n_total++; if (ack !== 4'b0100) $display("FAIL two_ack2 got %b exp 0100", ack); else n_pass++;
        n_total++; if (result !== 32'd60) $display("FAIL two_result2 got %0d exp 60", result); else n_pass++;
        n_total++; if (low < 3) $display("FAIL two_start_gap got %0d low samples exp >= 3", low); else n_pass++;
        wait_idle();
    endtask

    task automatic test_round_robin();
        int cyc, low;
        logic [3:0] exp_ack [6];
        logic [3:0] got;
        exp_ack = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        apply_reset();
        req_max = {32'd10, 32'd10, 32'd10, 32'd10};
        req = 4'b1111;
        for (int j = 0; j < 6; j++) begin
            wait_ack(cyc, low);
            got = ack;
            req = req & ~got;
            n_total++; if (got !== exp_ack[j]) $display("FAIL rr_order_%0d got %b exp %b", j, got, exp_ack[j]); else n_pass++;
            @(negedge clk);
            req = req | got;
        end
        req = 4'b0000;
        wait_idle();
    endtask

    task automatic test_max1();
        int cyc, low;
        req_max[63:32] = 32'd1; req = 4'b0010;
        wait_ack(cyc, low);
        req = 4'b0000;
        n_total++; if (ack !== 4'b0010) $display("FAIL max1_ack got %b exp 0010", ack); else n_pass++;
        n_total++; if (result !== 32'd0) $display("FAIL max1_result got %0d exp 0", result); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL max1_err got %b exp 0", err); else n_pass++;
        wait_idle();
    endtask

    task automatic test_timeout();
        int cyc, low;
        logic [15:0] jobs_before;
        jobs_before = jobs_done;
        req_max[127:96] = 32'd1000; req = 4'b1000;
        @(negedge clk);
        wait_ack(cyc, low);
        req = 4'b0000;
        n_total++; if (cyc !== 20) $display("FAIL to_run_cycles got %0d exp 20", cyc); else n_pass++;
        n_total++; if (ack !== 4'b1000) $display("FAIL to_ack got %b exp 1000", ack); else n_pass++;
        n_total++; if (err !== 1'b1) $display("FAIL to_err got %b exp 1", err); else n_pass++;
        n_total++; if (result !== 32'd0) $display("FAIL to_result got %0d exp 0", result); else n_pass++;
        n_total++; if (calc_reset !== 1'b1) $display("FAIL to_calc_reset got %b exp 1", calc_reset); else n_pass++;
        n_total++; if (jobs_done !== jobs_before) $display("FAIL to_jobs got %0d exp %0d", jobs_done, jobs_before); else n_pass++;
        @(negedge clk);
        n_total++; if (calc_reset !== 1'b0) $display("FAIL to_calc_reset_pulse got %b exp 0", calc_reset); else n_pass++;
        wait_idle();
        n_total++; if (err !== 1'b1) $display("FAIL to_err_hold got %b exp 1", err); else n_pass++;
        req_max[127:96] = 32'd10; req = 4'b1000;
        wait_ack(cyc, low);
        req = 4'b0000;
        n_total++; if (result !== 32'd23) $display("FAIL to_next_result got %0d exp 23", result); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL to_next_err got %b exp 0", err); else n_pass++;
        wait_idle();
    endtask

    task automatic test_reset_mid_run();
        int cyc, low;
        logic seen;
        req_max[31:0] = 32'd1000; req = 4'b0001;
        repeat (3) @(negedge clk);
        n_total++; if (calc_start !== 1'b1) $display("FAIL mid_start got %b exp 1", calc_start); else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_total++; if ({calc_start, busy, ack} !== 6'b000000)
            $display("FAIL mid_async got %b exp 000000", {calc_start, busy, ack}); else n_pass++;
        n_total++; if (calc_max !== 32'd0) $display("FAIL mid_calc_max got %0d exp 0", calc_max); else n_pass++;
        @(negedge clk);
        req = 4'b0000;
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (ack != 4'b0000) seen = 1'b1;
        end
        n_total++; if (seen !== 1'b0) $display("FAIL mid_no_ack got %b exp 0", seen); else n_pass++;
        req_max[31:0] = 32'd16; req = 4'b0001;
        wait_ack(cyc, low);
        req = 4'b0000;
        n_total++; if (ack !== 4'b0001) $display("FAIL mid_after_ack got %b exp 0001", ack); else n_pass++;
        n_total++; if (result !== 32'd60) $display("FAIL mid_after_result got %0d exp 60", result); else n_pass++;
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_two();
        test_round_robin();
        test_max1();
        test_timeout();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
